rob_ebr_multi: RTL and testbench

- Parametrised next-generation reorder buffer for the R10K out-of-order core.
- Dispatch width, retire width and completion-port count are independent parameters.
- Completion is addressed by ROB index, not by physical tag, so it does not depend on tag uniqueness.
- Adds exact early-branch-recovery (EBR) squash with an exact occupancy count, halt-aware retirement, and an explicit full/empty distinction.
- Sits between dispatch (stage/map table) and retire (architectural map table, free list).

---
 rtl/rob_ebr_multi_if.sv | 58 +++++
 rtl/rob_ebr_multi.sv | 207 ++++++++++++++++++++
 tb/tb_rob_ebr_multi.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_ebr_multi_if.sv
// rob_ebr_multi_if: dispatch / completion / squash / retire bundle for the
// rob_ebr_multi reorder buffer.
// Packets are carried as flat vectors. The ROB unpacks them into its own
// structs:
//   decoded packet = {valid, halt, op[OP_W-1:0]}
//   rob packet     = {valid, complete, halt, op, t[PR_W-1:0], t_old[PR_W-1:0]}
// Optional macro ROB_PERF_CNT_EN adds the performance-counter outputs.
interface rob_ebr_multi_if #(
    parameter int DEPTH = 32,
    parameter int N     = 2,
    parameter int RET_W = 2,
    parameter int CMP_W = 2,
    parameter int PR_W  = 6,
    parameter int OP_W  = 8
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NA_W  = $clog2(N + 1);
    localparam int NR_W  = $clog2(RET_W + 1);
    localparam int DEC_W = OP_W + 2;
    localparam int ROB_W = OP_W + 3 + 2 * PR_W;

    logic [N-1:0][DEC_W-1:0]     wr_data;
    logic [N-1:0][PR_W-1:0]      t;
    logic [N-1:0][PR_W-1:0]      t_old;
    logic [NA_W-1:0]             num_accept;
    logic [CMP_W-1:0]            cmp_valid;
    logic [CMP_W-1:0][IDX_W-1:0] cmp_idx;
    logic                        br_en;
    logic [IDX_W-1:0]            br_idx;
    logic [RET_W-1:0][ROB_W-1:0] retiring_data;
    logic [NR_W-1:0]             num_retired;
    logic [NA_W-1:0]             open_entries;
    logic [IDX_W-1:0]            out_tail;
    logic                        full;
    logic                        empty;
    logic                        halted;
`ifdef ROB_PERF_CNT_EN
    logic [31:0]                 perf_retired;
    logic [31:0]                 perf_squashed;
    logic [31:0]                 perf_full_cycles;
`endif

    modport master (
        output wr_data, t, t_old, num_accept, cmp_valid, cmp_idx, br_en, br_idx,
        input  retiring_data, num_retired, open_entries, out_tail, full, empty, halted
`ifdef ROB_PERF_CNT_EN
        , input perf_retired, perf_squashed, perf_full_cycles
`endif
    );

    modport slave (
        input  wr_data, t, t_old, num_accept, cmp_valid, cmp_idx, br_en, br_idx,
        output retiring_data, num_retired, open_entries, out_tail, full, empty, halted
`ifdef ROB_PERF_CNT_EN
        , output perf_retired, perf_squashed, perf_full_cycles
`endif
    );
endinterface

// File: rtl/rob_ebr_multi.sv
// rob_ebr_multi: circular reorder buffer with index-addressed completion,
// exact early-branch-recovery squash, exact occupancy count and halt-aware
// retirement.
// Optional macro ROB_PERF_CNT_EN adds saturating perf counters for retired
// entries, squashed entries and full cycles.
module rob_ebr_multi #(
    parameter int DEPTH = 32,
    parameter int N     = 2,
    parameter int RET_W = 2,
    parameter int CMP_W = 2,
    parameter int PR_W  = 6,
    parameter int OP_W  = 8
) (
    input  logic            clock,
    input  logic            reset,
    rob_ebr_multi_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NA_W  = $clog2(N + 1);
    localparam int NR_W  = $clog2(RET_W + 1);

    typedef struct packed {
        logic            valid;
        logic            halt;
        logic [OP_W-1:0] op;
    } dec_pkt_t;

    typedef struct packed {
        logic            valid;
        logic            complete;
        logic            halt;
        logic [OP_W-1:0] op;
        logic [PR_W-1:0] t;
        logic [PR_W-1:0] t_old;
    } rob_pkt_t;

    function automatic rob_pkt_t make_entry(input dec_pkt_t d,
                                            input logic [PR_W-1:0] t_i,
                                            input logic [PR_W-1:0] t_old_i);
        rob_pkt_t e;
        e.valid    = d.valid;
        e.complete = 1'b0;
        e.halt     = d.halt;
        e.op       = d.op;
        e.t        = t_i;
        e.t_old    = t_old_i;
        return e;
    endfunction

    rob_pkt_t         mem_q [DEPTH];
    rob_pkt_t         mem_d [DEPTH];
    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             halted_q, halted_d;

    logic [NR_W-1:0]             ret_n_s;
    logic                        ret_halt_s;
    logic                        scan_stop_s;
    logic [IDX_W-1:0]            ridx_s;
    logic [RET_W-1:0][$bits(rob_pkt_t)-1:0] ret_data_s;
    logic [CNT_W:0]              room_s;
    logic [NA_W-1:0]             open_s;
    logic [IDX_W-1:0]            br_off_s;
    logic [CNT_W-1:0]            surv_s;
    logic [CNT_W-1:0]            sq_len_s;
    logic [IDX_W-1:0]            base_s;
    logic [IDX_W-1:0]            widx_s;
    logic                        full_s;

    // Retire scan from head: stop at the first incomplete entry or just after a halt.
    always_comb begin
        ret_n_s     = '0;
        ret_halt_s  = 1'b0;
        scan_stop_s = halted_q;
        ridx_s      = head_q;
        ret_data_s  = '0;
        for (int i = 0; i < RET_W; i++) begin
            ridx_s = head_q + IDX_W'(i);
            if (!scan_stop_s && mem_q[ridx_s].valid && mem_q[ridx_s].complete) begin
                ret_n_s       = ret_n_s + NR_W'(1'b1);
                ret_data_s[i] = mem_q[ridx_s];
                scan_stop_s   = mem_q[ridx_s].halt;
                ret_halt_s    = mem_q[ridx_s].halt;
            end else begin
                scan_stop_s = 1'b1;
            end
        end
    end

    // Free slots this cycle, counting same-cycle retirement; none once halted.
    always_comb begin
        room_s = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + (CNT_W+1)'(ret_n_s);
        if (halted_q) begin
            open_s = '0;
        end else if (room_s >= (CNT_W+1)'(N)) begin
            open_s = NA_W'(N);
        end else begin
            open_s = NA_W'(room_s);
        end
    end

    // Squash geometry: survivors are head..br_idx inclusive, the rest of the live window dies.
    always_comb begin
        br_off_s = bus.br_idx - head_q;
        surv_s   = CNT_W'(br_off_s) + CNT_W'(1'b1);
        sq_len_s = count_q - surv_s;
        base_s   = bus.br_en ? (bus.br_idx + IDX_W'(1'b1)) : tail_q;
    end

    // Next-state entry array: complete, then squash (wins over complete), retire clear, dispatch.
    always_comb begin
        mem_d  = mem_q;
        widx_s = base_s;
        for (int p = 0; p < CMP_W; p++) begin
            mem_d[bus.cmp_idx[p]].complete = mem_d[bus.cmp_idx[p]].complete
                                           | (bus.cmp_valid[p] & mem_q[bus.cmp_idx[p]].valid);
        end
        for (int k = 0; k < DEPTH; k++) begin
            widx_s = bus.br_idx + IDX_W'(1'b1) + IDX_W'(k);
            mem_d[widx_s] = (bus.br_en && (CNT_W'(k) < sq_len_s)) ? rob_pkt_t'('0) : mem_d[widx_s];
        end
        for (int i = 0; i < RET_W; i++) begin
            widx_s = head_q + IDX_W'(i);
            mem_d[widx_s] = (NR_W'(i) < ret_n_s) ? rob_pkt_t'('0) : mem_d[widx_s];
        end
        for (int j = 0; j < N; j++) begin
            widx_s = base_s + IDX_W'(j);
            mem_d[widx_s] = (NA_W'(j) < bus.num_accept)
                          ? make_entry(dec_pkt_t'(bus.wr_data[j]), bus.t[j], bus.t_old[j])
                          : mem_d[widx_s];
        end
    end

    // Next-state pointers, exact count and sticky halt.
    always_comb begin
        head_d   = head_q + IDX_W'(ret_n_s);
        tail_d   = base_s + IDX_W'(bus.num_accept);
        halted_d = halted_q | ret_halt_s;
        if (bus.br_en) begin
            count_d = surv_s - CNT_W'(ret_n_s) + CNT_W'(bus.num_accept);
        end else begin
            count_d = count_q - CNT_W'(ret_n_s) + CNT_W'(bus.num_accept);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            halted_q <= halted_d;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= mem_d[k];
            end
        end
    end

    assign full_s            = (count_q == CNT_W'(DEPTH));
    assign bus.full          = full_s;
    assign bus.empty         = (count_q == '0);
    assign bus.halted        = halted_q;
    assign bus.num_retired   = ret_n_s;
    assign bus.retiring_data = ret_data_s;
    assign bus.open_entries  = open_s;
    assign bus.out_tail      = base_s;

    // Dispatching more slots than are open would overwrite live entries.
    a_accept_le_open: assert property (@(posedge clock) disable iff (reset)
                                       bus.num_accept <= open_s);

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_ret_q, perf_sq_q, perf_full_q;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Saturating event counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_ret_q  <= 32'd0;
            perf_sq_q   <= 32'd0;
            perf_full_q <= 32'd0;
        end else begin
            perf_ret_q  <= sat_add(perf_ret_q, 32'(ret_n_s));
            perf_sq_q   <= bus.br_en ? sat_add(perf_sq_q, 32'(sq_len_s)) : perf_sq_q;
            perf_full_q <= sat_add(perf_full_q, {31'd0, full_s});
        end
    end

    assign bus.perf_retired     = perf_ret_q;
    assign bus.perf_squashed    = perf_sq_q;
    assign bus.perf_full_cycles = perf_full_q;
`endif
endmodule

// File: tb/tb_rob_ebr_multi.sv
// Directed bench for rob_ebr_multi (DEPTH=8, N=2, RET_W=2, CMP_W=2).
// Expected retired packets are queued at dispatch time; a monitor pops and
// compares them whenever the ROB reports retirement.
module tb_rob_ebr_multi;
    localparam int DEPTH = 8;
    localparam int N     = 2;
    localparam int RET_W = 2;
    localparam int CMP_W = 2;
    localparam int PR_W  = 6;
    localparam int OP_W  = 8;
    localparam int DEC_W = OP_W + 2;
    localparam int ROB_W = OP_W + 3 + 2 * PR_W;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rob_ebr_multi_if #(.DEPTH(DEPTH), .N(N), .RET_W(RET_W), .CMP_W(CMP_W),
                       .PR_W(PR_W), .OP_W(OP_W)) bus ();

    rob_ebr_multi #(.DEPTH(DEPTH), .N(N), .RET_W(RET_W), .CMP_W(CMP_W),
                    .PR_W(PR_W), .OP_W(OP_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [ROB_W-1:0] exp_q[$];
    logic [ROB_W-1:0] mon_e;

    function automatic logic [DEC_W-1:0] mk_dec(input logic halt, input logic [7:0] op);
        return {1'b1, halt, op};
    endfunction

    function automatic logic [ROB_W-1:0] mk_rob(input logic halt, input logic [7:0] op);
        return {1'b1, 1'b1, halt, op, op[5:0] ^ 6'h20, op[5:0]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every reported retirement must match the queue head.
    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < RET_W; i++) begin
                if (i < int'(bus.num_retired)) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL retire_unexpected: slot %0d got %h, none expected",
                                 i, bus.retiring_data[i]);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (bus.retiring_data[i] !== mon_e) begin
                            n_fail++;
                            $display("FAIL retire_data: slot %0d got %h expected %h",
                                     i, bus.retiring_data[i], mon_e);
                        end
                    end
                end else begin
                    chk("retire_slot_zero", int'(bus.retiring_data[i]), 0);
                end
            end
        end
    end

    task automatic idle();
        bus.wr_data    = '0;
        bus.t          = '0;
        bus.t_old      = '0;
        bus.num_accept = '0;
        bus.cmp_valid  = '0;
        bus.cmp_idx    = '0;
        bus.br_en      = 1'b0;
        bus.br_idx     = '0;
    endtask

    task automatic next();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic put(input int slot, input logic halt, input logic [7:0] op, input logic will_retire);
        bus.wr_data[slot] = mk_dec(halt, op);
        bus.t[slot]       = op[5:0] ^ 6'h20;
        bus.t_old[slot]   = op[5:0];
        bus.num_accept    = 2'(slot + 1);
        if (will_retire) exp_q.push_back(mk_rob(halt, op));
    endtask

    task automatic cmp(input int port, input int idx);
        bus.cmp_valid[port] = 1'b1;
        bus.cmp_idx[port]   = 3'(idx);
    endtask

    task automatic status(input string tag, input int nret, input int open, input int tl,
                          input int fl, input int em, input int hl);
        @(negedge clock);
        chk({tag, ".num_retired"},  int'(bus.num_retired),  nret);
        chk({tag, ".open_entries"}, int'(bus.open_entries), open);
        chk({tag, ".out_tail"},     int'(bus.out_tail),     tl);
        chk({tag, ".full"},         int'(bus.full),         fl);
        chk({tag, ".empty"},        int'(bus.empty),        em);
        chk({tag, ".halted"},       int'(bus.halted),       hl);
    endtask

    task automatic hard_reset();
        chk("queue_drained", exp_q.size(), 0);
        next();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        status("reset", 0, 2, 0, 0, 1, 0);

        // Fill to full: 2 per cycle for 4 cycles, only the first two will retire.
        for (int c = 0; c < 4; c++) begin
            next();
            put(0, 1'b0, 8'(2 * c), c == 0);
            put(1, 1'b0, 8'(2 * c + 1), c == 0);
            status("fill", 0, 2, 2 * c, 0, (c == 0) ? 1 : 0, 0);
        end
        next();
        cmp(0, 0);
        cmp(1, 1);
        status("full", 0, 0, 0, 1, 0, 0);
        next();
        put(0, 1'b0, 8'd8, 1'b0);
        put(1, 1'b0, 8'd9, 1'b0);
        status("retire_refill", 2, 2, 0, 1, 0, 0);
        next();
        status("refilled", 0, 0, 2, 1, 0, 0);

        // Build head=6, tail=3, count=5 then squash behind index 7.
        hard_reset();
        next(); put(0, 1'b0, 8'd16, 1'b1); put(1, 1'b0, 8'd17, 1'b1);
        status("sq_c1", 0, 2, 0, 0, 1, 0);
        next(); put(0, 1'b0, 8'd18, 1'b1); put(1, 1'b0, 8'd19, 1'b1); cmp(0, 0); cmp(1, 1);
        status("sq_c2", 0, 2, 2, 0, 0, 0);
        next(); put(0, 1'b0, 8'd20, 1'b1); put(1, 1'b0, 8'd21, 1'b1); cmp(0, 2); cmp(1, 3);
        status("sq_c3", 2, 2, 4, 0, 0, 0);
        next(); cmp(0, 4); cmp(1, 5);
        status("sq_c4", 2, 2, 6, 0, 0, 0);
        next(); put(0, 1'b0, 8'd22, 1'b1); put(1, 1'b0, 8'd23, 1'b1);
        status("sq_c5", 2, 2, 6, 0, 0, 0);
        next(); put(0, 1'b0, 8'd24, 1'b0); put(1, 1'b0, 8'd25, 1'b0);
        status("sq_c6", 0, 2, 0, 0, 0, 0);
        next(); put(0, 1'b0, 8'd26, 1'b0);
        status("sq_c7", 0, 2, 2, 0, 0, 0);
        next(); bus.br_en = 1'b1; bus.br_idx = 3'd7; put(0, 1'b0, 8'd27, 1'b1);
        cmp(0, 2); cmp(1, 6);
        status("squash", 0, 2, 0, 0, 0, 0);
        next(); cmp(0, 7); cmp(1, 0);
        status("post_sq", 1, 2, 1, 0, 0, 0);
        next(); cmp(0, 1); cmp(1, 2);
        status("post_sq2", 2, 2, 1, 0, 0, 0);
        next();
        status("sq_drained", 0, 2, 1, 0, 1, 0);
        next();
        status("sq_dead", 0, 2, 1, 0, 1, 0);

        // Out-of-order completion: 2, then 1, then 0.
        hard_reset();
        next(); put(0, 1'b0, 8'd30, 1'b1); put(1, 1'b0, 8'd31, 1'b1);
        status("ord_c1", 0, 2, 0, 0, 1, 0);
        next(); put(0, 1'b0, 8'd32, 1'b1);
        status("ord_c2", 0, 2, 2, 0, 0, 0);
        next(); cmp(0, 2);
        status("ord_c3", 0, 2, 3, 0, 0, 0);
        next(); cmp(0, 1);
        status("ord_c4", 0, 2, 3, 0, 0, 0);
        next(); cmp(1, 0);
        status("ord_c5", 0, 2, 3, 0, 0, 0);
        next();
        status("ord_pair", 2, 2, 3, 0, 0, 0);
        next();
        status("ord_last", 1, 2, 3, 0, 0, 0);
        next();
        status("ord_empty", 0, 2, 3, 0, 1, 0);

        // Halt at index 1 behind index 0; index 2 must never retire.
        hard_reset();
        next(); put(0, 1'b0, 8'd40, 1'b1); put(1, 1'b1, 8'd41, 1'b1);
        status("halt_c1", 0, 2, 0, 0, 1, 0);
        next(); put(0, 1'b0, 8'd42, 1'b0); cmp(0, 0); cmp(1, 1);
        status("halt_c2", 0, 2, 2, 0, 0, 0);
        next(); cmp(0, 2);
        status("halt_ret", 2, 2, 3, 0, 0, 0);
        next();
        status("halted", 0, 0, 3, 0, 0, 1);
        next();
        status("halted2", 0, 0, 3, 0, 0, 1);

        // Asynchronous reset in mid-cycle with five live entries.
        hard_reset();
        next(); put(0, 1'b0, 8'd50, 1'b0); put(1, 1'b0, 8'd51, 1'b0);
        next(); put(0, 1'b0, 8'd52, 1'b0); put(1, 1'b0, 8'd53, 1'b0);
        next(); put(0, 1'b0, 8'd54, 1'b0);
        next();
        status("live5", 0, 2, 5, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("areset.empty",        int'(bus.empty),            1);
        chk("areset.out_tail",     int'(bus.out_tail),         0);
        chk("areset.open_entries", int'(bus.open_entries),     2);
        chk("areset.num_retired",  int'(bus.num_retired),      0);
        chk("areset.full",         int'(bus.full),             0);
        chk("areset.retire0",      int'(bus.retiring_data[0]), 0);
        chk("areset.retire1",      int'(bus.retiring_data[1]), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        next();
        status("after_areset", 0, 2, 0, 0, 1, 0);

        chk("queue_final", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
